chipscope_probe_sched: RTL and testbench
========================================

// Module: chipscope_probe_sched
// PURPOSE
//  Shares one 48-bit ILA trigger/data port between NUM_SRC probe groups
//  (e.g. rx data/err/cnt per lane). Takes commands from an asynchronous
//  VIO output word and returns status on a VIO input word. Supports static
//  source select and timed round-robin scan. Sits between transceiver probe
//  taps and the icon/ila/shared_vio cores in the ChipScope wrapper.
// PARAMETERS
//  NUM_SRC  4   probe groups muxed (1..256)
//  PROBE_W  48  width of each group and of ila_trig
//  SEL_W    2   select width; must be >= clog2(NUM_SRC), minimum 1
// PORTS
//  CLK         in   1                 capture clock (same clock as the ILA CLK)
//  RST_N       in   1                 asynchronous, active-low reset
//  vio_cmd     in   32                command word from VIO ASYNC_OUT (async)
//  vio_status  out  32                status word to VIO ASYNC_IN
//  probe_in    in   NUM_SRC*PROBE_W   group i at [i*PROBE_W +: PROBE_W]
//  ila_trig    out  PROBE_W           selected group, registered, to ILA TRIG0
//  ila_sel     out  SEL_W             source index aligned with ila_trig
//  ila_switch  out  1                 1-cycle pulse on first sample of a new source
// BEHAVIOUR
//  Reset: all outputs 0; sel=0; state IDLE; ack_tgl=0; err=0; cnt=0; sync regs=0.
//  Cmd format: [31] toggle, [27:24] opcode, [15:0] arg; other bits ignored.
//  Sync: all 32 bits pass 2 flops (s1->s2), then s3<=s2.
//   Accept when s2==s3 and s2[31]!=ack_tgl. A word must be steady for at
//   least 2 synced cycles, so 1-cycle glitches are rejected.
//   Latency: accept fires 3 CLK cycles after vio_cmd settles.
//  On accept, all in the same edge: ack_tgl<=s2[31]; cnt<=cnt+1 (8b, wraps).
//   Then the opcode executes:
//   0 NOP   : no further effect
//   1 SELECT: if arg<NUM_SRC then sel<=arg and state<=IDLE;
//             otherwise err<=1, sel and state unchanged
//   2 SCAN  : state<=SCAN; dwell<=max(arg,1); sel unchanged
//   3 STOP  : state<=IDLE; sel holds its current value
//   4 CLEAR : err<=0; cnt<=0 (the clear overrides this cycle's increment)
//   5-15    : treated as NOP
//  Because ack_tgl resets to 0, a word with [31]=1 present at reset release
//   executes exactly once.
//  FSM IDLE: sel static. FSM SCAN: dwell_cnt counts down by 1 per cycle.
//   At 1 it reloads dwell and sel<=(sel==NUM_SRC-1)?0:sel+1.
//   Each source is therefore held for exactly dwell cycles.
//  Collision: an accept and a dwell expiry in the same cycle -> the command
//   wins; no advance occurs; dwell_cnt reloads only if the opcode is SCAN.
//  Datapath: ila_trig<=probe_in[sel]; ila_sel<=sel; both 1 cycle after sel.
//   ila_switch<=(sel!=sel_q), where sel_q is sel delayed 1 cycle; it is
//   aligned with ila_trig.
//   With NUM_SRC=1: sel stays 0 and ila_switch never pulses.
//  vio_status: [31] ack_tgl, [30] state==SCAN, [29] err (sticky),
//   [23:16] cnt, [7:0] sel zero-extended; other bits 0; registered.
//  RST_N assertion mid-scan: outputs clear immediately (asynchronous).
//   After release the block is in IDLE with sel=0.
// TESTING
//  1 Reset: RST_N low mid-SCAN -> all outputs 0 with no clock edge.
//    Release with vio_cmd=0 -> nothing accepted, status stays 0.
//  2 SELECT: vio_cmd=0x8100_0002 held -> within 3 cycles status=0x8001_0002;
//    next cycle ila_trig=probe group 2, ila_sel=2, one ila_switch pulse.
//  3 Bad arg: vio_cmd=0x0100_0005 after test 2, NUM_SRC=4 -> sel stays 2,
//    status[29]=1, status[31]=0, cnt=2; then 0x8400_0000 -> err=0, cnt=0.
//  4 SCAN: vio_cmd=0x8200_0003 from sel=0 -> ila_sel sequence 0,1,2,3,0,
//    each value held 3 cycles; ila_switch pulses on every change;
//    status[30]=1. Arg 0 -> each source held 1 cycle.
//  5 Glitch: bit 31 toggles for 1 synced cycle only -> no accept, no ack
//    change. Skewed multi-bit update settling in 2 cycles -> exactly 1 accept.
//  6 Collision: STOP accepted on the dwell-expiry cycle -> sel unchanged,
//    status[30]=0, no ila_switch pulse.

Source files
------------

// File: rtl/chipscope_probe_sched.sv
// chipscope_probe_sched
// Multiplexes NUM_SRC probe groups onto one ILA trigger port. Commands come
// from an asynchronous VIO output word through a 2-flop synchroniser plus a
// stability stage. A command is accepted when the synchronised word has been
// steady for two cycles and its toggle bit differs from the last acknowledged
// toggle. Supports static select and timed round-robin scanning.
module chipscope_probe_sched #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned PROBE_W = 48,
    parameter int unsigned SEL_W   = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [31:0]                vio_cmd,
    output logic [31:0]                vio_status,
    input  logic [NUM_SRC*PROBE_W-1:0] probe_in,
    output logic [PROBE_W-1:0]         ila_trig,
    output logic [SEL_W-1:0]           ila_sel,
    output logic                       ila_switch
);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    localparam logic [3:0] OP_SELECT = 4'd1;
    localparam logic [3:0] OP_SCAN   = 4'd2;
    localparam logic [3:0] OP_STOP   = 4'd3;
    localparam logic [3:0] OP_CLEAR  = 4'd4;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);

    // Synchroniser and stability stages
    logic [31:0] s1_q, s2_q, s3_q;

    // Control state
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [15:0]       dwell_q, dwell_d;
    logic [15:0]       dwell_cnt_q, dwell_cnt_d;
    logic [31:0]       status_q, status_d;

    // Datapath pipeline
    logic [SEL_W-1:0]   sel_dly_q;
    logic [PROBE_W-1:0] trig_q, trig_d;
    logic [SEL_W-1:0]   ila_sel_q;
    logic               switch_q;

    // Decoded command fields
    logic              accept;
    logic [3:0]        opcode;
    logic [15:0]       arg;
    logic [15:0]       arg_dwell;
    logic              arg_ok;
    logic [31:0]       sel_ext;

    assign opcode    = s2_q[27:24];
    assign arg       = s2_q[15:0];
    assign accept    = (s2_q == s3_q) && (s2_q[31] != ack_q);
    assign arg_dwell = (arg == 16'd0) ? 16'd1 : arg;
    assign arg_ok    = ({16'd0, arg} < 32'(NUM_SRC));

    // Bring the async command word into the CLK domain and keep a stable copy
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= vio_cmd;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Control and status registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            status_q    <= status_d;
        end
    end

    // Next-state: scan timer first, then an accepted command overrides it
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ack_d       = ack_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;

        if (state_q == ST_SCAN) begin
            if (dwell_cnt_q == 16'd1) begin
                // An accept on the expiry cycle suppresses the advance and
                // leaves the timer parked unless the command reloads it.
                if (!accept) begin
                    dwell_cnt_d = dwell_q;
                    sel_d       = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
                end
            end else begin
                dwell_cnt_d = dwell_cnt_q - 16'd1;
            end
        end

        if (accept) begin
            ack_d = s2_q[31];
            cnt_d = cnt_q + 8'd1;
            case (opcode)
                OP_SELECT: begin
                    if (arg_ok) begin
                        sel_d   = SEL_W'(arg);
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_SCAN: begin
                    state_d     = ST_SCAN;
                    dwell_d     = arg_dwell;
                    dwell_cnt_d = arg_dwell;
                end
                OP_STOP: begin
                    state_d = ST_IDLE;
                end
                OP_CLEAR: begin
                    err_d = 1'b0;
                    cnt_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Status word built from next-state so it updates with the registers
    always_comb begin
        sel_ext  = 32'(sel_d);
        status_d = {ack_d, (state_d == ST_SCAN), err_d, 5'd0,
                    cnt_d, 8'd0, sel_ext[7:0]};
    end

    // Probe group mux for the current selection
    always_comb begin
        trig_d = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SEL_W'(i)) begin
                trig_d = probe_in[i*PROBE_W +: PROBE_W];
            end
        end
    end

    // Output pipeline: trigger, index and switch pulse aligned one cycle after sel
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_dly_q <= '0;
            trig_q    <= '0;
            ila_sel_q <= '0;
            switch_q  <= 1'b0;
        end else begin
            sel_dly_q <= sel_q;
            trig_q    <= trig_d;
            ila_sel_q <= sel_q;
            switch_q  <= (sel_q != sel_dly_q);
        end
    end

    assign vio_status = status_q;
    assign ila_trig   = trig_q;
    assign ila_sel    = ila_sel_q;
    assign ila_switch = switch_q;

endmodule

// File: tb/tb_chipscope_probe_sched.sv
// Directed bench for chipscope_probe_sched with a scoreboard for scan sequences.
module tb_chipscope_probe_sched;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned PROBE_W = 48;
    localparam int unsigned SEL_W   = 2;

    logic                       CLK;
    logic                       RST_N;
    logic [31:0]                vio_cmd;
    logic [31:0]                vio_status;
    logic [NUM_SRC*PROBE_W-1:0] probe_in;
    logic [PROBE_W-1:0]         ila_trig;
    logic [SEL_W-1:0]           ila_sel;
    logic                       ila_switch;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [SEL_W-1:0] sel;
        logic             sw;
    } exp_t;

    exp_t sb[$];

    chipscope_probe_sched #(
        .NUM_SRC(NUM_SRC),
        .PROBE_W(PROBE_W),
        .SEL_W  (SEL_W)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .vio_cmd   (vio_cmd),
        .vio_status(vio_status),
        .probe_in  (probe_in),
        .ila_trig  (ila_trig),
        .ila_sel   (ila_sel),
        .ila_switch(ila_switch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] grp(input int i);
        return {16'hA5A5 ^ 16'(i), 16'(i * 3 + 1), 16'hC000 + 16'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a command word and wait (bounded) for its toggle to be acknowledged
    task automatic send(input string tag, input logic [31:0] w);
        int n;
        vio_cmd = w;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (vio_status[31] !== w[31] && n < 12);
        chk({tag, "_ack"}, 64'(vio_status[31]), 64'(w[31]));
    endtask

    // Pop expected ILA samples one per cycle
    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge CLK);
            e = sb.pop_front();
            chk({tag, "_sel"}, 64'(ila_sel), 64'(e.sel));
            chk({tag, "_sw"},  64'(ila_switch), 64'(e.sw));
            chk({tag, "_trig"}, 64'(ila_trig), 64'(grp(int'(e.sel))));
        end
    endtask

    initial begin
        for (int i = 0; i < int'(NUM_SRC); i++) probe_in[i*PROBE_W +: PROBE_W] = grp(i);
        vio_cmd = '0;
        RST_N   = 1'b1;
        #2 RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_status", 64'(vio_status), 64'h0);
        chk("rst_trig",   64'(ila_trig),   64'h0);
        chk("rst_sel",    64'(ila_sel),    64'h0);
        chk("rst_sw",     64'(ila_switch), 64'h0);
        RST_N = 1'b1;

        // 1: asynchronous reset in the middle of a scan
        send("t1_scan", 32'h8200_0002);
        chk("t1_scan_status", 64'(vio_status), 64'hC001_0000);
        repeat (5) @(negedge CLK);
        #2 RST_N = 1'b0;
        vio_cmd = '0;
        #1;
        chk("t1_async_status", 64'(vio_status), 64'h0);
        chk("t1_async_trig",   64'(ila_trig),   64'h0);
        chk("t1_async_sel",    64'(ila_sel),    64'h0);
        chk("t1_async_sw",     64'(ila_switch), 64'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        chk("t1_idle_status", 64'(vio_status), 64'h0);
        chk("t1_idle_sel",    64'(ila_sel),    64'h0);

        // 2: static select of group 2
        send("t2_sel", 32'h8100_0002);
        chk("t2_status", 64'(vio_status), 64'h8001_0002);
        sb.push_back('{sel: 2'd2, sw: 1'b1});
        sb.push_back('{sel: 2'd2, sw: 1'b0});
        drain("t2");

        // 3: out-of-range select, then clear
        send("t3_bad", 32'h0100_0005);
        chk("t3_bad_status", 64'(vio_status), 64'h2002_0002);
        @(negedge CLK);
        chk("t3_bad_sel", 64'(ila_sel), 64'd2);
        send("t3_clr", 32'h8400_0000);
        chk("t3_clr_status", 64'(vio_status), 64'h8000_0002);

        // 4: scan with dwell 3 from group 0, then dwell 0 (treated as 1)
        send("t4_sel0", 32'h0100_0000);
        chk("t4_sel0_status", 64'(vio_status), 64'h0001_0000);
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 15; k++)
            sb.push_back('{sel: SEL_W'((k / 3) % 4), sw: (k % 3 == 0) && (k > 0)});
        send("t4_scan3", 32'h8200_0003);
        chk("t4_scan3_status", 64'(vio_status), 64'hC002_0000);
        drain("t4_d3");
        send("t4_stop", 32'h0300_0000);
        chk("t4_stop_status", 64'(vio_status & 32'hC0FF_0000), 64'h0003_0000);
        send("t4_sel0b", 32'h8100_0000);
        chk("t4_sel0b_status", 64'(vio_status), 64'h8004_0000);
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 6; k++)
            sb.push_back('{sel: SEL_W'(k % 4), sw: (k > 0)});
        send("t4_scan0", 32'h0200_0000);
        chk("t4_scan0_status", 64'(vio_status), 64'h4005_0000);
        drain("t4_d1");
        send("t4_stop2", 32'h8300_0000);
        chk("t4_stop2_status", 64'(vio_status & 32'hC0FF_0000), 64'h8006_0000);

        // 5: glitch rejection and skewed multi-bit update
        send("t5_sel1", 32'h0100_0001);
        chk("t5_sel1_status", 64'(vio_status), 64'h0007_0001);
        vio_cmd = 32'h8100_0001;
        @(negedge CLK);
        vio_cmd = 32'h0100_0001;
        repeat (8) @(negedge CLK);
        chk("t5_glitch_status", 64'(vio_status), 64'h0007_0001);
        vio_cmd = 32'h8100_0003;
        @(negedge CLK);
        vio_cmd = 32'h8000_0003;
        repeat (8) @(negedge CLK);
        chk("t5_skew_status", 64'(vio_status), 64'h8008_0001);

        // 6: STOP lands exactly on the second dwell expiry
        send("t6_scan5", 32'h0200_0005);
        chk("t6_scan5_status", 64'(vio_status), 64'h4009_0001);
        repeat (6) @(negedge CLK);
        send("t6_stop", 32'h8300_0000);
        chk("t6_stop_status", 64'(vio_status), 64'h800A_0002);
        for (int k = 0; k < 6; k++) sb.push_back('{sel: 2'd2, sw: 1'b0});
        drain("t6");
        chk("t6_final_status", 64'(vio_status), 64'h800A_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
